// File: rtl/addern_ctrl_if.sv
// Bus bundle between addern_ctrl and its surroundings: board-side operand inputs, adder links and display outputs.
// The sub signal exists only when ADDERN_SUB_EN is defined.
interface addern_ctrl_if #(
    parameter int N = 4
);
    logic         load;
    logic [N-1:0] data;
    logic         accum;
`ifdef ADDERN_SUB_EN
    logic         sub;
`endif
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
    logic [N-1:0] result;
    logic         carry;
    logic         overflow;
    logic         valid;
    logic [1:0]   state;

    // Surrounding logic: drives operands and the adder's outputs, observes the controller.
    modport master (
`ifdef ADDERN_SUB_EN
        output sub,
`endif
        output load, data, accum, sum, cout,
        input  x, y, cin, result, carry, overflow, valid, state
    );

    modport slave (
`ifdef ADDERN_SUB_EN
        input  sub,
`endif
        input  load, data, accum, sum, cout,
        output x, y, cin, result, carry, overflow, valid, state
    );
endinterface

// File: rtl/addern_ctrl.sv
// Sequencing controller for the combinational addern adder: captures operands on Load edges and registers the sum.
// Define ADDERN_SUB_EN to add the Sub input (Y = ~B, Cin = 1 for two's-complement subtraction).
module addern_ctrl #(
    parameter int n = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    addern_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_ADD  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_load_d;
    logic         w_pulse;
    logic         w_sub_in;

    logic [n-1:0] r_x;
    logic [n-1:0] r_b;
    logic         r_sub;
    logic [n-1:0] r_result;
    logic         r_carry;
    logic         r_ovf;
    logic         r_valid;

    logic [n-1:0] w_x_nxt;
    logic [n-1:0] w_b_nxt;
    logic         w_sub_nxt;
    logic [n-1:0] w_result_nxt;
    logic         w_carry_nxt;
    logic         w_ovf_nxt;
    logic         w_valid_nxt;
    logic [n-1:0] w_y;

`ifdef ADDERN_SUB_EN
    assign w_sub_in = bus.sub;
`else
    assign w_sub_in = 1'b0;
`endif

    assign w_pulse = bus.load & ~r_load_d;

    // Y is the effective operand: B, or ~B with Cin=1 when subtracting; both come straight from flops.
    assign w_y = r_b ^ {n{r_sub}};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_A;
            r_load_d <= 1'b1;
            r_x      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_load_d <= bus.load;
            r_x      <= w_x_nxt;
            r_b      <= w_b_nxt;
            r_sub    <= w_sub_nxt;
            r_result <= w_result_nxt;
            r_carry  <= w_carry_nxt;
            r_ovf    <= w_ovf_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_b_nxt      = r_b;
        w_sub_nxt    = r_sub;
        w_result_nxt = r_result;
        w_carry_nxt  = r_carry;
        w_ovf_nxt    = r_ovf;
        w_valid_nxt  = r_valid;

        case (r_state)
            S_A: begin
                if (w_pulse) begin
                    w_x_nxt     = bus.data;
                    w_state_nxt = S_B;
                end
            end
            S_B: begin
                if (w_pulse) begin
                    w_b_nxt     = bus.data;
                    w_sub_nxt   = w_sub_in;
                    w_state_nxt = S_ADD;
                end
            end
            // Single settle cycle for the adder; any pulse arriving here is dropped.
            S_ADD: begin
                w_result_nxt = bus.sum;
                w_carry_nxt  = bus.cout;
                w_ovf_nxt    = (r_x[n-1] == w_y[n-1]) && (bus.sum[n-1] != r_x[n-1]);
                w_valid_nxt  = 1'b1;
                w_state_nxt  = S_DONE;
            end
            S_DONE: begin
                if (w_pulse) begin
                    w_valid_nxt = 1'b0;
                    if (bus.accum) begin
                        w_x_nxt     = r_result;
                        w_b_nxt     = bus.data;
                        w_sub_nxt   = w_sub_in;
                        w_state_nxt = S_ADD;
                    end else begin
                        w_x_nxt     = bus.data;
                        w_state_nxt = S_B;
                    end
                end
            end
            default: w_state_nxt = S_A;
        endcase
    end

    assign bus.x        = r_x;
    assign bus.y        = w_y;
    assign bus.cin      = r_sub;
    assign bus.result   = r_result;
    assign bus.carry    = r_carry;
    assign bus.overflow = r_ovf;
    assign bus.valid    = r_valid;
    assign bus.state    = r_state;

endmodule

// File: doc/addern_ctrl.md
Name: addern_ctrl

Overview:
- Sequencing controller wrapped around the combinational `addern` adder.
- Captures two operands from a shared data bus on debounced load strobes and drives X, Y and Cin into the adder.
- Registers the adder's Sum and Cout one cycle later and presents Result, Carry and signed Overflow with a Valid flag.
- Supports accumulate mode, where the previous Result becomes operand A. Sits between board inputs (SW/KEY) and display logic.

Parameters:
- n, 4, operand/result width in bits; must match the paired `addern` instance.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Load  in  1  operand strobe, level input, already debounced; block edge-detects internally.
- Data  in  n  operand value, sampled on the cycle a Load rising edge is detected.
- Accum  in  1  accumulate select, sampled at the Load edge in S_DONE.
- Sub  in  1  subtract select; present only when ADDERN_SUB_EN is defined.
- X  out  n  operand A to adder, registered.
- Y  out  n  effective operand B to adder, registered.
- Cin  out  1  carry-in to adder, registered.
- Sum  in  n  adder sum.
- Cout  in  1  adder carry-out.
- Result  out  n  registered sum.
- Carry  out  1  registered Cout.
- Overflow  out  1  registered signed (two's-complement) overflow.
- Valid  out  1  high while Result/Carry/Overflow are meaningful.
- State  out  2  current FSM state, for LED display.

Behaviour:
- Reset values: state S_A; X, Y, Result = 0; Cin, Carry, Overflow, Valid = 0; internal operand-B register = 0; Load_d = 1.
  - Load_d resetting to 1 means a Load held high through reset release does not produce a pulse.
- Edge detect: pulse = Load & ~Load_d; Load_d <= Load every cycle. A held Load yields exactly one pulse.
- FSM encoding: S_A=00, S_B=01, S_ADD=10, S_DONE=11.
  - S_A: on pulse, X <= Data, go to S_B.
  - S_B: on pulse, capture Data as B, drive Y/Cin (see arithmetic), go to S_ADD.
  - S_ADD: exactly one cycle; X/Y/Cin stable. At the end of the cycle:
    - Result <= Sum, Carry <= Cout.
    - Overflow <= (X[n-1] == Y[n-1]) && (Sum[n-1] != X[n-1]).
    - Valid <= 1; go to S_DONE.
  - S_DONE: outputs held, Valid = 1. On pulse, Valid <= 0, then:
    - If Accum = 1: X <= Result, B <= Data, drive Y/Cin, go to S_ADD.
    - If Accum = 0: X <= Data, go to S_B.
  - Pulses in S_ADD are dropped, not queued.
  - No pulse: state and all registers hold.
- Arithmetic (base build): Y <= B, Cin <= 0.
  - Result is the modulo-2^n sum; Carry is bit n.
  - Latency: Load edge on B to Valid high = 2 cycles (edge-detect register plus S_ADD).
- Reset asserted mid-operation: immediate return to reset values regardless of state; any partial operand is discarded.
- Y is the effective operand (post-inversion) so the Overflow formula is the same for add and subtract.

Optional Feature:
- Macro: ADDERN_SUB_EN.
- Defined:
  - Sub port exists; Sub is sampled with B at the capture edge.
  - If Sub = 1: Y <= ~B, Cin <= 1, so Result = X - B mod 2^n.
  - Carry = 1 means no borrow (X >= B unsigned).
  - Overflow uses the same formula, applied to the inverted Y.
- Undefined: Sub port absent; Y <= B, Cin <= 0 always.

Test Plan (n=4, bench pairs block with an `addern` instance):
- Reset, then Load pulses with Data=5 then Data=3 -> State 00→01→10→11; Result=1000, Carry=0, Overflow=1, Valid=1 two cycles after second edge.
- Data=9 then Data=8 -> Result=0001, Carry=1, Overflow=1; then Accum=1, Load with Data=2 -> Result=0011, Carry=0, Overflow=0, one S_ADD cycle, State never visits 00/01.
- Load held high for 20 cycles after Data=6 -> single capture, State=01 only; Load held high across Reset deassert -> State stays 00.
- Reset pulsed while in S_B with X=7 -> X=0, Valid=0, State=00 within the same cycle (asynchronous); following sequence 2+2 -> Result=0100.
- Extra Load pulse in S_ADD cycle -> ignored, Result correct, State=11.
- With ADDERN_SUB_EN: 3 - 5 -> Result=1110, Carry=0, Overflow=0; 0111 - 1000 (7 - (-8)) -> Result=1111, Overflow=1, Carry=0.
